// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the UART async FIFO (read and write sides).
//  - FIFO_A_DEF / FIFO_P_DEF : default address width and almost threshold
//  - GRAY_MAX_W              : widest pointer the Gray helpers handle
//  - bin2gray / gray2bin     : Gray <-> binary conversion. Callers cast their
//                              pointer up to GRAY_MAX_W (zero-extend) and
//                              cast the result back down. Zero upper bits
//                              leave the low-order result unchanged, so any
//                              pointer width up to GRAY_MAX_W is supported.
// ----------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned FIFO_A_DEF = 3;
   localparam int unsigned FIFO_P_DEF = 4;
   localparam int unsigned GRAY_MAX_W = 16;

   // Binary to reflected Gray code.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Reflected Gray code to binary: each bit is the XOR of all Gray bits at or above it.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// ----------------------------------------------------------------------------
// ptr_sync
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Only one bit changes per pointer step, so a metastable sample resolves to
// either the old or the new pointer value.
// Ports:
//  clk    in   1      destination-domain clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  d      in   WIDTH  Gray pointer from the source domain
//  q      out  WIDTH  synchronised pointer (second flop stage)
// ----------------------------------------------------------------------------
module ptr_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q1_r;
   logic [WIDTH-1:0] q2_r;

   // Two-stage capture of the asynchronous pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_r <= {WIDTH{1'b0}};
         q2_r <= {WIDTH{1'b0}};
      end else begin
         q1_r <= d;
         q2_r <= q1_r;
      end
   end

   assign q = q2_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side control for the UART async FIFO. Owns the read pointer (binary
// and Gray), synchronises the write pointer into rclk and produces the
// read-domain status flags. Memory read data is combinational from raddr.
// Ports:
//  rclk           in   1    read-domain clock, rising edge
//  rrst_n         in   1    asynchronous active-low reset
//  rinc           in   1    read request, honoured only while rempty=0
//  wptr           in   A+1  Gray write pointer from the wclk domain
//  rptr           out  A+1  Gray read pointer, registered, to write domain
//  raddr          out  A    memory read address (low bits of binary pointer)
//  rempty         out  1    FIFO empty, registered
//  ralmost_empty  out  1    occupancy <= P, registered
//  rlevel         out  A+1  read-domain occupancy 0..D, registered
//  rundf          out  1    sticky underflow, cleared only by reset
// ----------------------------------------------------------------------------
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned A = FIFO_A_DEF,
   parameter int unsigned P = FIFO_P_DEF
) (
   input  logic         rclk,
   input  logic         rrst_n,
   input  logic         rinc,
   input  logic [A:0]   wptr,
   output logic [A:0]   rptr,
   output logic [A-1:0] raddr,
   output logic         rempty,
   output logic         ralmost_empty,
   output logic [A:0]   rlevel,
   output logic         rundf
);

   localparam int unsigned PW    = A + 1;
   localparam logic [A:0]  P_LVL = PW'(P);

   logic [A:0] rq2_wptr_s;
   logic [A:0] rbin_r;
   logic       rinc_ok_s;
   logic [A:0] rbinnext_s;
   logic [A:0] rgraynext_s;
   logic [A:0] wbin_s;
   logic [A:0] lvl_next_s;

   ptr_sync #(
      .WIDTH (PW)
   ) u_wptr_sync (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d     (wptr),
      .q     (rq2_wptr_s)
   );

   // Next read pointer and read-domain occupancy. Both use the pointer after
   // this cycle's read, so a read and a newly synchronised write land in the
   // same edge's level and cancel out.
   always_comb begin
      rinc_ok_s   = rinc & ~rempty;
      rbinnext_s  = rbin_r + {{(PW-1){1'b0}}, rinc_ok_s};
      rgraynext_s = PW'(bin2gray(GRAY_MAX_W'(rbinnext_s)));
      wbin_s      = PW'(gray2bin(GRAY_MAX_W'(rq2_wptr_s)));
      // Modulo 2**(A+1) subtraction handles the pointer wrap seamlessly.
      lvl_next_s  = wbin_s - rbinnext_s;
   end

   // Read pointer, status flags and sticky underflow.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_r        <= {PW{1'b0}};
         rptr          <= {PW{1'b0}};
         rempty        <= 1'b1;
         ralmost_empty <= 1'b1;
         rlevel        <= {PW{1'b0}};
         rundf         <= 1'b0;
      end else begin
         rbin_r        <= rbinnext_s;
         rptr          <= rgraynext_s;
         // Gray compare: equal pointers (MSB included) means empty, not full.
         rempty        <= (rgraynext_s == rq2_wptr_s);
         ralmost_empty <= (lvl_next_s <= P_LVL);
         rlevel        <= lvl_next_s;
         rundf         <= rundf | (rinc & rempty);
      end
   end

   assign raddr = rbin_r[A-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl (A=3, P=4). The reference model keeps
// plain write/read counts and a short history of the write count seen at each
// rclk edge; the read side acts on the count sampled two edges earlier.
// ----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

   localparam int A = 3;
   localparam int P = 4;
   localparam int D = 8;

   logic         rclk;
   logic         rrst_n;
   logic         rinc;
   logic [A:0]   wptr;
   logic [A:0]   rptr;
   logic [A-1:0] raddr;
   logic         rempty;
   logic         ralmost_empty;
   logic [A:0]   rlevel;
   logic         rundf;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int   wr_cnt;
   int   rd_cnt;
   int   m_lvl;
   logic m_empty;
   logic m_ae;
   logic m_undf;
   int   sq[$];

   fifo_rd_ctrl #(.A(A), .P(P)) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rinc          (rinc),
      .wptr          (wptr),
      .rptr          (rptr),
      .raddr         (raddr),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel),
      .rundf         (rundf)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   function automatic logic [3:0] g4(input int x);
      logic [3:0] b;
      b = x[3:0];
      return b ^ (b >> 1);
   endfunction

   // One rclk cycle: drive at negedge, model the edge, settle 1 time unit.
   task automatic tick(input logic inc, input int nwr);
      int seen;
      @(negedge rclk);
      rinc   = inc;
      wr_cnt = wr_cnt + nwr;
      wptr   = g4(wr_cnt);
      @(posedge rclk);
      seen = (sq.size() >= 2) ? sq[sq.size()-2] : 0;
      sq.push_back(wr_cnt);
      if (sq.size() > 4) void'(sq.pop_front());
      if (inc) begin
         if (m_empty) m_undf = 1'b1;
         else         rd_cnt++;
      end
      m_lvl   = seen - rd_cnt;
      m_empty = (m_lvl == 0);
      m_ae    = (m_lvl <= P);
      #1;
      rinc = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge rclk);
      #3;
      rrst_n = 1'b0;
      #1;
      n_checks++; if (rempty !== 1'b1) $display("FAIL reset_rempty got %b exp 1", rempty); else n_pass++;
      n_checks++; if (ralmost_empty !== 1'b1) $display("FAIL reset_ralmost_empty got %b exp 1", ralmost_empty); else n_pass++;
      n_checks++; if (rlevel !== 4'd0) $display("FAIL reset_rlevel got %0d exp 0", rlevel); else n_pass++;
      n_checks++; if (rptr !== 4'b0000) $display("FAIL reset_rptr got %b exp 0000", rptr); else n_pass++;
      n_checks++; if (raddr !== 3'd0) $display("FAIL reset_raddr got %0d exp 0", raddr); else n_pass++;
      n_checks++; if (rundf !== 1'b0) $display("FAIL reset_rundf got %b exp 0", rundf); else n_pass++;
      rinc    = 1'b0;
      wr_cnt  = 0;
      wptr    = 4'b0000;
      rd_cnt  = 0;
      m_lvl   = 0;
      m_empty = 1'b1;
      m_ae    = 1'b1;
      m_undf  = 1'b0;
      sq.delete();
      @(negedge rclk);
      rrst_n = 1'b1;
   endtask

   task automatic test_single();
      test_reset();
      tick(1'b0, 1);
      tick(1'b0, 0);
      n_checks++; if (rempty !== 1'b1) $display("FAIL single_early_empty got %b exp 1", rempty); else n_pass++;
      tick(1'b0, 0);
      n_checks++; if (rempty !== 1'b0) $display("FAIL single_rempty_3rd got %b exp 0", rempty); else n_pass++;
      n_checks++; if (rlevel !== 4'd1) $display("FAIL single_rlevel got %0d exp 1", rlevel); else n_pass++;
      tick(1'b1, 0);
      n_checks++; if (raddr !== 3'd1) $display("FAIL single_raddr got %0d exp 1", raddr); else n_pass++;
      n_checks++; if (rptr !== 4'b0001) $display("FAIL single_rptr got %b exp 0001", rptr); else n_pass++;
      n_checks++; if (rempty !== 1'b1) $display("FAIL single_last_empty got %b exp 1", rempty); else n_pass++;
      n_checks++; if (rlevel !== 4'd0) $display("FAIL single_last_rlevel got %0d exp 0", rlevel); else n_pass++;
   endtask

   task automatic test_full_drain();
      test_reset();
      tick(1'b0, 8);
      tick(1'b0, 0);
      tick(1'b0, 0);
      n_checks++; if (rlevel !== 4'd8) $display("FAIL full_rlevel got %0d exp 8", rlevel); else n_pass++;
      n_checks++; if (ralmost_empty !== 1'b0) $display("FAIL full_ae got %b exp 0", ralmost_empty); else n_pass++;
      for (int i = 0; i < 4; i++) tick(1'b1, 0);
      n_checks++; if (rlevel !== 4'd4) $display("FAIL half_rlevel got %0d exp 4", rlevel); else n_pass++;
      n_checks++; if (ralmost_empty !== 1'b1) $display("FAIL half_ae got %b exp 1", ralmost_empty); else n_pass++;
      n_checks++; if (rempty !== 1'b0) $display("FAIL half_rempty got %b exp 0", rempty); else n_pass++;
      for (int i = 0; i < 4; i++) tick(1'b1, 0);
      n_checks++; if (rempty !== 1'b1) $display("FAIL drain_rempty got %b exp 1", rempty); else n_pass++;
      n_checks++; if (rlevel !== 4'd0) $display("FAIL drain_rlevel got %0d exp 0", rlevel); else n_pass++;
      n_checks++; if (rptr !== 4'b1100) $display("FAIL drain_rptr got %b exp 1100", rptr); else n_pass++;
      n_checks++; if (raddr !== 3'd0) $display("FAIL drain_raddr got %0d exp 0", raddr); else n_pass++;
   endtask

   task automatic test_wrap();
      int k;
      logic [2:0] exp_a;
      test_reset();
      for (int i = 0; i < 2 * D; i++) begin
         tick(1'b0, 1);
         k = 0;
         while (rempty !== 1'b0 && k < 10) begin
            tick(1'b0, 0);
            k++;
         end
         n_checks++; if (rempty !== 1'b0) $display("FAIL wrap_timeout iter %0d rempty %b exp 0", i, rempty); else n_pass++;
         exp_a = 3'(i % D);
         n_checks++; if (raddr !== exp_a) $display("FAIL wrap_raddr iter %0d got %0d exp %0d", i, raddr, exp_a); else n_pass++;
         tick(1'b1, 0);
      end
      n_checks++; if (rptr !== 4'b0000) $display("FAIL wrap_rptr got %b exp 0000", rptr); else n_pass++;
      n_checks++; if (rundf !== 1'b0) $display("FAIL wrap_rundf got %b exp 0", rundf); else n_pass++;
   endtask

   task automatic test_underflow();
      logic [2:0] a0;
      logic [3:0] p0;
      a0 = raddr;
      p0 = rptr;
      n_checks++; if (rempty !== 1'b1) $display("FAIL undf_pre_empty got %b exp 1", rempty); else n_pass++;
      tick(1'b1, 0);
      tick(1'b1, 0);
      n_checks++; if (raddr !== a0) $display("FAIL undf_raddr got %0d exp %0d", raddr, a0); else n_pass++;
      n_checks++; if (rptr !== p0) $display("FAIL undf_rptr got %b exp %b", rptr, p0); else n_pass++;
      n_checks++; if (rundf !== 1'b1) $display("FAIL undf_set got %b exp 1", rundf); else n_pass++;
      for (int i = 0; i < 3; i++) tick(1'b0, 0);
      n_checks++; if (rundf !== 1'b1) $display("FAIL undf_sticky got %b exp 1", rundf); else n_pass++;
      test_reset();
   endtask

   task automatic test_concurrent();
      test_reset();
      tick(1'b0, 5);
      tick(1'b0, 0);
      tick(1'b0, 0);
      n_checks++; if (rlevel !== 4'd5) $display("FAIL conc_pre_rlevel got %0d exp 5", rlevel); else n_pass++;
      tick(1'b1, 1);
      tick(1'b0, 0);
      tick(1'b0, 0);
      n_checks++; if (rlevel !== 4'd5) $display("FAIL conc_rlevel got %0d exp 5", rlevel); else n_pass++;
      n_checks++; if (raddr !== 3'd1) $display("FAIL conc_raddr got %0d exp 1", raddr); else n_pass++;
      test_reset();
   endtask

   task automatic test_random();
      int nwr;
      logic inc;
      test_reset();
      for (int i = 0; i < 300; i++) begin
         nwr = ((wr_cnt - rd_cnt) < D && $urandom_range(0, 99) < 45) ? 1 : 0;
         inc = ($urandom_range(0, 99) < 50);
         tick(inc, nwr);
         n_checks++; if (rempty !== m_empty) $display("FAIL rnd_rempty cyc %0d got %b exp %b", i, rempty, m_empty); else n_pass++;
         n_checks++; if (ralmost_empty !== m_ae) $display("FAIL rnd_ae cyc %0d got %b exp %b", i, ralmost_empty, m_ae); else n_pass++;
         n_checks++; if (rlevel !== 4'(m_lvl)) $display("FAIL rnd_rlevel cyc %0d got %0d exp %0d", i, rlevel, m_lvl); else n_pass++;
         n_checks++; if (rptr !== g4(rd_cnt)) $display("FAIL rnd_rptr cyc %0d got %b exp %b", i, rptr, g4(rd_cnt)); else n_pass++;
         n_checks++; if (raddr !== 3'(rd_cnt % D)) $display("FAIL rnd_raddr cyc %0d got %0d exp %0d", i, raddr, rd_cnt % D); else n_pass++;
         n_checks++; if (rundf !== m_undf) $display("FAIL rnd_rundf cyc %0d got %b exp %b", i, rundf, m_undf); else n_pass++;
      end
   endtask

   initial begin
      rrst_n = 1'b1;
      rinc   = 1'b0;
      wptr   = 4'b0000;
      test_reset();
      test_single();
      test_full_drain();
      test_wrap();
      test_underflow();
      test_concurrent();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
